fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/dlx_pkg.sv | 10 +
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// dlx_pkg: shared word type, PC step and fetch FSM encoding for the DLX front end.
package dlx_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t PC_INC = 32'd4;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} fetch_state_e;
    function automatic word_t align_word(input word_t a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus a single-outstanding instruction fetch FSM
// with a req/gnt/rvalid memory handshake and a sticky overrun flag.
module fetch_unit
    import dlx_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  if_en,
    input  logic  wb_en,
    input  logic  pc_load,
    input  word_t pc_target,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  word_t imem_rdata,
    output word_t pc,
    output word_t npc,
    output word_t ir,
    output logic  ir_valid,
    output logic  fetch_busy,
    output logic  overrun
);
    fetch_state_e r_state;
    word_t        r_pc, r_addr, r_ir;
    logic         r_req, r_ir_valid, r_overrun;
    word_t        w_npc;

    assign w_npc      = r_pc + PC_INC;
    assign pc         = r_pc;
    assign npc        = w_npc;
    assign ir         = r_ir;
    assign ir_valid   = r_ir_valid;
    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign overrun    = r_overrun;
    assign fetch_busy = r_state != ST_IDLE;

    // The PC path is independent of the FSM so write-back never disturbs an in-flight address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_req      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            if (wb_en)
                r_pc <= pc_load ? align_word(pc_target) : w_npc;
            if (if_en && r_state != ST_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: if (if_en) begin
                    r_addr  <= r_pc;
                    r_req   <= 1'b1;
                    r_state <= ST_REQ;
                end
                ST_REQ: if (imem_gnt) begin
                    r_req <= 1'b0;
                    if (imem_rvalid) begin
                        r_ir       <= imem_rdata;
                        r_ir_valid <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (imem_rvalid) begin
                    r_ir       <= imem_rdata;
                    r_ir_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized fetch/write-back scenarios checked against a PC/IR model.
module tb_fetch_unit;
    import dlx_pkg::*;

    logic  clk = 1'b0, reset_n = 1'b0, if_en = 1'b0, wb_en = 1'b0, pc_load = 1'b0;
    logic  imem_gnt = 1'b0, imem_rvalid = 1'b0;
    word_t pc_target = '0, imem_rdata = '0;
    logic  imem_req, ir_valid, fetch_busy, overrun;
    word_t imem_addr, pc, npc, ir;

    int    n_checks = 0, n_fail = 0;
    word_t m_pc = 32'h0, m_ir = 32'h0;
    logic  m_ovr = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .if_en(if_en), .wb_en(wb_en), .pc_load(pc_load),
        .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc), .npc(npc), .ir(ir),
        .ir_valid(ir_valid), .fetch_busy(fetch_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic load, input word_t tgt);
        wb_en = 1'b1; pc_load = load; pc_target = tgt;
        tick;
        wb_en = 1'b0; pc_load = 1'b0;
        m_pc = load ? (tgt & ~32'd3) : m_pc + 32'd4;
        n_checks++;
        if (pc !== m_pc || npc !== m_pc + 32'd4) begin
            n_fail++;
            $display("FAIL wb_pc: pc=%h npc=%h, required pc=%h npc=%h", pc, npc, m_pc, m_pc + 32'd4);
        end
    endtask

    // Full fetch: gnt after gdly request cycles, rvalid rdly cycles after gnt (0 = same cycle).
    task automatic run_fetch(input int gdly, input int rdly, input word_t data);
        word_t addr;
        addr = m_pc;
        if_en = 1'b1;
        tick;
        if_en = 1'b0;
        for (int i = 0; i <= gdly; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== addr || fetch_busy !== 1'b1 || ir_valid !== 1'b0 || ir !== m_ir) begin
                n_fail++;
                $display("FAIL req_hold[%0d]: req=%b addr=%h busy=%b irv=%b ir=%h, required req=1 addr=%h busy=1 irv=0 ir=%h",
                         i, imem_req, imem_addr, fetch_busy, ir_valid, ir, addr, m_ir);
            end
            if (i < gdly) begin
                imem_rvalid = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                tick;
                imem_rvalid = 1'b0;
            end
        end
        imem_gnt = 1'b1; imem_rvalid = (rdly == 0); imem_rdata = data;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        for (int i = 1; i <= rdly; i++) begin
            n_checks++;
            if (imem_req !== 1'b0 || fetch_busy !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== addr) begin
                n_fail++;
                $display("FAIL wait[%0d]: req=%b busy=%b irv=%b addr=%h, required req=0 busy=1 irv=0 addr=%h",
                         i, imem_req, fetch_busy, ir_valid, imem_addr, addr);
            end
            imem_rvalid = (i == rdly);
            imem_rdata = (i == rdly) ? data : $urandom;
            tick;
            imem_rvalid = 1'b0;
        end
        m_ir = data;
        n_checks++;
        if (ir_valid !== 1'b1 || ir !== data || fetch_busy !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL done: irv=%b ir=%h busy=%b req=%b, required irv=1 ir=%h busy=0 req=0",
                     ir_valid, ir, fetch_busy, imem_req, data);
        end
        tick;
        n_checks++;
        if (ir_valid !== 1'b0 || ir !== m_ir || overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL hold: irv=%b ir=%h ovr=%b, required irv=0 ir=%h ovr=%b", ir_valid, ir, overrun, m_ir, m_ovr);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick; tick;
        reset_n = 1'b1;
        m_pc = 32'h0; m_ir = 32'h0; m_ovr = 1'b0;
        n_checks++;
        if (pc !== 32'h0 || npc !== 32'h4 || ir !== 32'h0 || ir_valid !== 1'b0 || imem_req !== 1'b0 ||
            fetch_busy !== 1'b0 || overrun !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: pc=%h npc=%h ir=%h irv=%b req=%b busy=%b ovr=%b addr=%h, required 0/4/0/0/0/0/0/0",
                     pc, npc, ir, ir_valid, imem_req, fetch_busy, overrun, imem_addr);
        end
    endtask

    task automatic test_basic;
        run_fetch(0, 0, 32'h2001_0005);
        n_checks++;
        if (npc !== 32'h4) begin
            n_fail++;
            $display("FAIL basic_npc: npc=%h, required 00000004", npc);
        end
    endtask

    task automatic test_delayed;
        run_fetch(3, 2, 32'hA5A5_0F0F);
    endtask

    task automatic test_branch;
        wb(1'b1, 32'h0000_0103);
        run_fetch(0, 1, 32'h1234_5678);
    endtask

    task automatic test_wrap;
        wb(1'b1, 32'hFFFF_FFFF);
        wb(1'b0, 32'h0);
    endtask

    task automatic test_wb_during_fetch;
        word_t old;
        old = m_pc;
        if_en = 1'b1;
        tick;
        if_en = 1'b0;
        wb(1'b1, 32'h0000_2002);
        n_checks++;
        if (imem_addr !== old || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_in_fetch: addr=%h req=%b, required addr=%h req=1", imem_addr, imem_req, old);
        end
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        m_ir = 32'hCAFE_0001;
        n_checks++;
        if (ir !== m_ir || ir_valid !== 1'b1 || pc !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL wb_in_fetch_done: ir=%h irv=%b pc=%h, required ir=%h irv=1 pc=00002000", ir, ir_valid, pc, m_ir);
        end
        tick;
    endtask

    task automatic test_same_cycle;
        word_t old;
        old = m_pc;
        if_en = 1'b1; wb_en = 1'b1; pc_load = 1'b0;
        tick;
        if_en = 1'b0; wb_en = 1'b0;
        m_pc = m_pc + 32'd4;
        n_checks++;
        if (imem_addr !== old || pc !== m_pc || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle: addr=%h pc=%h req=%b, required addr=%h pc=%h req=1", imem_addr, pc, imem_req, old, m_pc);
        end
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        m_ir = 32'h0BAD_F00D;
        tick;
    endtask

    task automatic test_random;
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) wb(1'($urandom_range(0, 1)), $urandom);
            run_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end
    endtask

    task automatic test_overrun;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre: ovr=%b, required 0", overrun);
        end
        if_en = 1'b1;
        tick;
        if_en = 1'b0; imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; if_en = 1'b1;
        tick;
        if_en = 1'b0;
        m_ovr = 1'b1;
        n_checks++;
        if (overrun !== 1'b1 || imem_req !== 1'b0 || fetch_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b req=%b busy=%b, required ovr=1 req=0 busy=1", overrun, imem_req, fetch_busy);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h7777_1111;
        tick;
        imem_rvalid = 1'b0;
        m_ir = 32'h7777_1111;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++;
            if (overrun !== 1'b1 || imem_req !== 1'b0 || fetch_busy !== 1'b0 || ir !== m_ir) begin
                n_fail++;
                $display("FAIL overrun_sticky[%0d]: ovr=%b req=%b busy=%b ir=%h, required ovr=1 req=0 busy=0 ir=%h",
                         i, overrun, imem_req, fetch_busy, ir, m_ir);
            end
        end
        run_fetch(1, 1, 32'h5555_AAAA);
    endtask

    task automatic test_reset_mid_fetch;
        if_en = 1'b1;
        tick;
        if_en = 1'b0; imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        m_pc = 32'h0; m_ir = 32'h0; m_ovr = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ir !== 32'h0 || ir_valid !== 1'b0 || fetch_busy !== 1'b0 || overrun !== 1'b0 || pc !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: ir=%h irv=%b busy=%b ovr=%b pc=%h, required 0/0/0/0/0",
                         i, ir, ir_valid, fetch_busy, overrun, pc);
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_delayed;
        test_branch;
        test_wrap;
        test_wb_during_fetch;
        test_same_cycle;
        test_random;
        test_overrun;
        test_reset_mid_fetch;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
